dot_product_ctrl: RTL and testbench
===================================

DOT_PRODUCT_CTRL -- requirements
Module: dot_product_ctrl

Interface
REQ-001 SHALL have parameters: N, 16, operand width; LEN_W, 10, term-count and address width.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic on posedge.
REQ-003 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port start_i, input, 1, request one dot product; sampled only in IDLE.
REQ-005 SHALL have port len_i, input, LEN_W, term count L (0 allowed); latched with start.
REQ-006 SHALL have port bias_i, input signed, 2N, accumulator seed; latched with start.
REQ-007 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-008 SHALL have ports rd_en_o (output, 1) and addr_o (output, LEN_W), read strobe and term index to operand memory.
REQ-009 SHALL have ports value_i and weight_i, input signed, N each, operand data, valid exactly 1 cycle after rd_en_o.
REQ-010 SHALL have ports mac_en_o (output, 1), mac_value_o and mac_mult_o (output signed, N), mac_add_o (output signed, 2N), driving an external MAC.
REQ-011 SHALL have port mac_i, input signed, 2N, external MAC registered output (1-cycle MAC latency).
REQ-012 SHALL have ports valid_o (output, 1), ready_i (input, 1), result_o (output signed, 2N), result handshake.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FLUSH, OUT.
REQ-014 IDLE with start_i=1: latch len_i and bias_i; go to RUN if L>0, else FLUSH.
REQ-015 RUN: assert rd_en_o each cycle with addr_o = 0,1,...,L-1; after the cycle issuing L-1, go to FLUSH.
REQ-016 mac_en_o SHALL be rd_en_o delayed one cycle; mac_value_o/mac_mult_o SHALL equal value_i/weight_i in that cycle.
REQ-017 mac_add_o SHALL be latched bias on the first enabled MAC cycle of a job, and mac_i on later ones.
REQ-018 With L=0, FLUSH SHALL assert mac_en_o once with mac_value_o=0, mac_mult_o=0, mac_add_o=bias.
REQ-019 FLUSH lasts exactly 1 cycle, then OUT.
REQ-020 OUT: valid_o=1, result_o derived from mac_i; hold both stable until ready_i=1; on valid_o&ready_i go to IDLE.
REQ-021 Latency SHALL be exactly L+2 cycles from start-accept edge to first valid_o cycle.
REQ-022 Arithmetic SHALL be two's complement, wraps modulo 2^(2N), no saturation.
REQ-023 start_i outside IDLE SHALL be ignored; len_i/bias_i changes after accept SHALL not affect the job.
REQ-024 start_i in the same cycle as the OUT handshake SHALL be ignored; the next job is accepted from IDLE.
REQ-025 rd_en_o, mac_en_o SHALL be 0 in IDLE and OUT; addr_o SHALL be 0 outside RUN.

Reset
REQ-026 rst_i=1 at a clock edge SHALL force IDLE from any state, including mid-RUN, and abandon the job.
REQ-027 Reset values: busy_o, rd_en_o, mac_en_o, valid_o = 0; addr_o, mac_value_o, mac_mult_o, mac_add_o, result_o = 0; latched len and bias = 0.
REQ-028 Controller SHALL not rely on clearing the external MAC; the bias seed of REQ-017 restarts accumulation.

Configuration
REQ-029 Macro DOT_RELU_EN defined: result_o = 0 when mac_i is negative, else mac_i; not defined: result_o = mac_i unchanged.

Verification
REQ-030 N=8, L=3, values 2,3,4, weights 5,6,7, bias 10, ready_i=1 -> addr 0,1,2; result_o=66 with valid_o at start+5.
REQ-031 L=0, bias=-7 -> valid_o at start+2; result_o=-7, or 0 with DOT_RELU_EN.
REQ-032 L=1, value=-3, weight=4, bias=0 -> result_o=-12, or 0 with DOT_RELU_EN; valid_o at start+3.
REQ-033 Job done, ready_i low 4 cycles, start_i pulsed meanwhile -> valid_o and result_o stable; start ignored; IDLE after handshake.
REQ-034 L=5, rst_i pulsed during RUN at addr_o=2 -> next cycle IDLE, all outputs 0; new job L=2 then returns the correct sum, with no residue from the aborted job.

Source files
------------

// File: rtl/dot_product_ctrl.sv
// dot_product_ctrl
// Sequencer for one signed dot product per request. It reads L operand
// pairs from an external memory, feeds them to an external MAC and returns
// the accumulated result through a valid/ready handshake.
//
// Build option: define DOT_RELU_EN to clamp negative results to zero.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               job request, only sampled in IDLE
//   len_i, bias_i         term count L (0 allowed) and accumulator seed
//   busy_o                high whenever a job is in progress
//   rd_en_o, addr_o       operand read strobe and term index
//   value_i, weight_i     operand data, valid one cycle after rd_en_o
//   mac_en_o              external MAC enable
//   mac_value_o/mult_o    MAC multiplicands
//   mac_add_o             MAC addend (bias on first term, then mac_i)
//   mac_i                 registered MAC output (1-cycle latency)
//   valid_o, ready_i      result handshake
//   result_o              dot product result
module dot_product_ctrl #(
    parameter int N     = 16,
    parameter int LEN_W = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic signed [2*N-1:0] bias_i,
    output logic                  busy_o,
    output logic                  rd_en_o,
    output logic [LEN_W-1:0]      addr_o,
    input  logic signed [N-1:0]   value_i,
    input  logic signed [N-1:0]   weight_i,
    output logic                  mac_en_o,
    output logic signed [N-1:0]   mac_value_o,
    output logic signed [N-1:0]   mac_mult_o,
    output logic signed [2*N-1:0] mac_add_o,
    input  logic signed [2*N-1:0] mac_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic signed [2*N-1:0] result_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state, state_next;

    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      addr_q;
    logic signed [2*N-1:0] bias_q;
    logic                  rd_q;     // rd_en_o delayed: operand data valid now
    logic                  first_q;  // next MAC operation is the first of the job
    logic                  accept;
    logic                  last_term;

    assign last_term = (addr_q == len_q - LEN_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy_o     = 1'b1;
        rd_en_o    = 1'b0;
        addr_o     = '0;
        valid_o    = 1'b0;
        result_o   = '0;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    accept     = 1'b1;
                    state_next = (len_i == '0) ? FLUSH : RUN;
                end
            end
            RUN: begin
                rd_en_o = 1'b1;
                addr_o  = addr_q;
                if (last_term) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next = OUT;
            end
            OUT: begin
                valid_o = 1'b1;
`ifdef DOT_RELU_EN
                result_o = mac_i[2*N-1] ? '0 : mac_i;
`else
                result_o = mac_i;
`endif
                if (ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // MAC side: the last RUN read lands in FLUSH, so FLUSH only needs its own
    // enable for the empty job, where it injects bias + 0*0.
    always_comb begin
        mac_en_o    = rd_q | ((state == FLUSH) && (len_q == '0));
        mac_value_o = rd_q ? value_i  : '0;
        mac_mult_o  = rd_q ? weight_i : '0;
        mac_add_o   = '0;
        if (mac_en_o) begin
            mac_add_o = first_q ? bias_q : mac_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q   <= '0;
            bias_q  <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            first_q <= 1'b0;
        end else begin
            rd_q <= rd_en_o;
            if (accept) begin
                len_q   <= len_i;
                bias_q  <= bias_i;
                addr_q  <= '0;
                first_q <= 1'b1;
            end else begin
                if (rd_en_o) begin
                    addr_q <= addr_q + LEN_W'(1);
                end
                if (mac_en_o) begin
                    first_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Self-checking bench for dot_product_ctrl (N=8, LEN_W=10) with an operand
// memory model and an external MAC model.
module tb_dot_product_ctrl;

    localparam int N     = 8;
    localparam int LEN_W = 10;

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic                  start_i;
    logic [LEN_W-1:0]      len_i;
    logic signed [2*N-1:0] bias_i;
    logic                  busy_o;
    logic                  rd_en_o;
    logic [LEN_W-1:0]      addr_o;
    logic signed [N-1:0]   value_i;
    logic signed [N-1:0]   weight_i;
    logic                  mac_en_o;
    logic signed [N-1:0]   mac_value_o;
    logic signed [N-1:0]   mac_mult_o;
    logic signed [2*N-1:0] mac_add_o;
    logic signed [2*N-1:0] mac_i;
    logic                  valid_o;
    logic                  ready_i;
    logic signed [2*N-1:0] result_o;

    always #5 clk = ~clk;

    dot_product_ctrl #(.N(N), .LEN_W(LEN_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .len_i       (len_i),
        .bias_i      (bias_i),
        .busy_o      (busy_o),
        .rd_en_o     (rd_en_o),
        .addr_o      (addr_o),
        .value_i     (value_i),
        .weight_i    (weight_i),
        .mac_en_o    (mac_en_o),
        .mac_value_o (mac_value_o),
        .mac_mult_o  (mac_mult_o),
        .mac_add_o   (mac_add_o),
        .mac_i       (mac_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .result_o    (result_o)
    );

    // Operand memory: registered read, garbage whenever not read.
    logic signed [N-1:0] mem_v [8];
    logic signed [N-1:0] mem_w [8];
    always @(posedge clk) begin
        if (rd_en_o) begin
            value_i  <= mem_v[addr_o[2:0]];
            weight_i <= mem_w[addr_o[2:0]];
        end else begin
            value_i  <= N'($urandom);
            weight_i <= N'($urandom);
        end
    end

    // External MAC: never cleared, starts from a non-zero value.
    logic signed [2*N-1:0] mac_q = 16'sh5A5A;
    always @(posedge clk) begin
        if (mac_en_o) mac_q <= mac_add_o + mac_value_o * mac_mult_o;
    end
    assign mac_i = mac_q;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [15:0] expect_res(input logic signed [15:0] raw);
`ifdef DOT_RELU_EN
        return (raw < 0) ? 16'sd0 : raw;
`else
        return raw;
`endif
    endfunction

    typedef struct {
        logic signed [15:0] res;
        longint             cyc;
    } exp_t;
    exp_t sb[$];
    int   exp_addr = 0;

    // Output monitor: address sequence and result/latency scoreboard.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_i) begin
            if (rd_en_o) begin
                chk("addr", addr_o, exp_addr);
                exp_addr++;
            end
            if (valid_o && !prev_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", valid_o, 0);
                end else begin
                    e = sb.pop_front();
                    chk("result", result_o, e.res);
                    chk("valid_cycle", cyc, e.cyc);
                end
            end
        end
        prev_valid = valid_o && !rst_i;
    end

    task automatic load(input logic [63:0] v, input logic [63:0] w);
        for (int i = 0; i < 8; i++) begin
            mem_v[i] = v[8*i +: 8];
            mem_w[i] = w[8*i +: 8];
        end
    endtask

    // Start cycle k; first valid cycle expected at k+L+2. Inputs are
    // scrambled after acceptance; poke keeps start_i high one extra cycle.
    task automatic start_job(input int len, input logic signed [15:0] bias,
                             input logic signed [15:0] raw, input bit poke);
        exp_t e;
        @(posedge clk); #1;
        len_i    = LEN_W'(len);
        bias_i   = bias;
        start_i  = 1'b1;
        exp_addr = 0;
        e.res    = expect_res(raw);
        e.cyc    = cyc + longint'(len) + 2;
        sb.push_back(e);
        @(posedge clk); #1;
        len_i   = LEN_W'($urandom);
        bias_i  = 16'($urandom);
        start_i = poke;
        if (poke) begin
            @(posedge clk); #1;
            start_i = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy_o || sb.size() != 0) && n < 100);
        if (busy_o || sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy=%0d pending=%0d, expected idle with none pending",
                     name, busy_o, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},      busy_o, 0);
        chk({tag, "_rd_en"},     rd_en_o, 0);
        chk({tag, "_addr"},      addr_o, 0);
        chk({tag, "_mac_en"},    mac_en_o, 0);
        chk({tag, "_mac_value"}, mac_value_o, 0);
        chk({tag, "_mac_mult"},  mac_mult_o, 0);
        chk({tag, "_mac_add"},   mac_add_o, 0);
        chk({tag, "_valid"},     valid_o, 0);
        chk({tag, "_result"},    result_o, 0);
    endtask

    typedef struct {
        int                 len;
        logic signed [15:0] bias;
        logic [63:0]        v;     // term i in bits [8i+7:8i]
        logic [63:0]        w;
        logic signed [15:0] raw;   // expected sum before optional clamp
        bit                 poke;
    } vec_t;
    vec_t vecs[7];

    initial begin
        vecs[0] = '{len: 3, bias: 16'sd10,    v: 64'h040302, w: 64'h070605, raw: 16'sd66,     poke: 1'b0};
        vecs[1] = '{len: 0, bias: -16'sd7,    v: 64'h7F7F,   w: 64'h7F7F,   raw: -16'sd7,     poke: 1'b1};
        vecs[2] = '{len: 1, bias: 16'sd0,     v: 64'hFD,     w: 64'h04,     raw: -16'sd12,    poke: 1'b0};
        vecs[3] = '{len: 2, bias: 16'sd0,     v: 64'h6464,   w: 64'h7F7F,   raw: 16'sd25400,  poke: 1'b1};
        vecs[4] = '{len: 3, bias: 16'sd0,     v: 64'h7F7F7F, w: 64'h7F7F7F, raw: -16'sd17149, poke: 1'b0};
        vecs[5] = '{len: 4, bias: 16'sd100,   v: 64'h80808080, w: 64'h80808080, raw: 16'sd100, poke: 1'b0};
        vecs[6] = '{len: 8, bias: -16'sd1000, v: 64'h0807060504030201,
                    w: 64'hFFFFFFFFFFFFFFFF, raw: -16'sd1036, poke: 1'b1};

        rst_i   = 1'b1;
        start_i = 1'b0;
        ready_i = 1'b1;
        len_i   = '0;
        bias_i  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_i = 1'b0;

        for (int i = 0; i < 7; i++) begin
            load(vecs[i].v, vecs[i].w);
            start_job(vecs[i].len, vecs[i].bias, vecs[i].raw, vecs[i].poke);
            wait_idle($sformatf("vec%0d", i));
        end

        // Back-pressure: hold ready low, pulse start during OUT, then
        // handshake with start high in the same cycle.
        begin
            int n = 0;
            ready_i = 1'b0;
            load(64'hFE03, 64'h0509);
            start_job(2, 16'sd1, 16'sd18, 1'b0);
            while (!valid_o && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("stall_valid_seen", valid_o, 1);
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                start_i = (i % 2 == 0);
                len_i   = LEN_W'(3);
                @(negedge clk);
                chk("stall_valid",  valid_o, 1);
                chk("stall_result", result_o, expect_res(16'sd18));
                chk("stall_busy",   busy_o, 1);
            end
            @(posedge clk); #1;
            ready_i = 1'b1;
            start_i = 1'b1;
            @(negedge clk);
            chk("handshake_valid", valid_o, 1);
            @(posedge clk); #1;
            start_i = 1'b0;
            @(negedge clk);
            chk("after_handshake_busy",  busy_o, 0);
            chk("after_handshake_valid", valid_o, 0);
            @(negedge clk);
            chk("handshake_start_ignored", busy_o, 0);
            wait_idle("stall");
        end

        // Reset mid-RUN at addr 2, then a clean job with the MAC left dirty.
        begin
            int n = 0;
            load(64'h0B0B0B0B0B0B0B0B, 64'h0D0D0D0D0D0D0D0D);
            start_job(5, 16'sd500, 16'sd1215, 1'b0);
            while (!(rd_en_o && addr_o == 2) && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("abort_reached_addr2", addr_o, 2);
            rst_i = 1'b1;
            sb.delete();
            @(negedge clk);
            check_zero("abort");
            rst_i = 1'b0;
            @(negedge clk);
            chk("abort_stays_idle", busy_o, 0);
            load(64'h0807, 64'h0302);
            start_job(2, -16'sd5, 16'sd33, 1'b0);
            wait_idle("after_abort");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
